im_loader: RTL and testbench

Instruction-memory loader: accepts a program image as a byte stream over a valid/ready handshake, packs bytes into 32-bit words and writes them sequentially into the instruction memory that the fetch stage reads. It holds the CPU in reset while loading and releases it on completion, so fetch restarts at 0x00003000 against a freshly written image. Sits between the host/debug byte link and the IM write port.

---
 rtl/im_loader_pkg.sv | 29 ++
 rtl/im_word_pack.sv | 60 ++++++
 rtl/im_loader.sv | 171 +++++++++++++++++
 tb/tb_im_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared types and constants for the instruction-memory loader.
//   state_e        loader FSM states
//   IM_DEPTH       instruction-memory depth in words
//   IM_BASE_PC     PC that IM word index 0 maps to
//   byte-lane constants and place_byte() for big-endian packing
package im_loader_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned IM_DEPTH       = 1024;
  localparam logic [31:0] IM_BASE_PC     = 32'h0000_3000;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Lane index of the byte that completes a word (the lowest byte, bits 7:0).
  localparam logic [1:0] LANE_LAST = 2'd3;

  // Byte number idx of a word lands big-endian: idx 0 -> bits 31:24, idx 3 -> bits 7:0.
  // The shift amount is (3 - idx) * 8, and ~idx equals 3 - idx for a 2-bit index.
  function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [1:0] idx);
    return 32'(b) << {~idx, 3'b000};
  endfunction

endpackage

// File: rtl/im_word_pack.sv
// im_word_pack: packs a byte stream into big-endian 32-bit words.
//   clk_i         system clock
//   reset_i       synchronous active-high reset (drops any partial word)
//   clear_i       start of a new session, discards buffered bytes
//   accept_i      a byte is transferred this cycle
//   flush_i       accepted byte is the last of the image; emit the word padded with zeros
//   byte_i        byte being transferred
//   word_valid_o  a word completes this cycle (combinational, same cycle as accept_i)
//   word_o        completed word, valid with word_valid_o
module im_word_pack
  import im_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic        flush_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;

  // Buffer lanes below the current byte are always zero, so OR-ing the new byte in
  // yields the zero-padded word directly for a flush.
  always_comb begin
    word_o       = buf_q | place_byte(byte_i, cnt_q);
    word_valid_o = accept_i & ((cnt_q == LANE_LAST) | flush_i);
  end

  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clear_i) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (accept_i) begin
      if (word_valid_o) begin
        cnt_d = '0;
        buf_d = '0;
      end else begin
        cnt_d = cnt_q + 2'd1;
        buf_d = word_o;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/im_loader.sv
// im_loader: loads a program image from a byte stream into instruction memory and holds
// the CPU in reset until the image is complete.
// Optional feature macro: IM_LOADER_CHECKSUM_EN (XOR checksum of written words).
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset, returns to idle
//   start_i        one-cycle request to begin a load session (idle or done only)
//   in_byte_i      image byte
//   in_valid_i     in_byte_i / in_last_i valid
//   in_last_i      final byte of the image
//   in_ready_o     byte accepted this cycle when in_valid_i is high
//   im_we_o        IM write strobe, one cycle per word
//   im_addr_o      IM word index (index 0 = PC IM_BASE_PC)
//   im_wdata_o     word to write
//   cpu_hold_o     CPU/IFU reset, low only once loading is done
//   busy_o         loading or flushing
//   done_o         session complete
//   err_o          sticky overflow flag for the current session
//   word_count_o   words written this session
//   checksum_o     XOR of written words (zero when the checksum is not built)
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [7:0]        in_byte_i,
  input  logic              in_valid_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       im_wdata_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic [31:0]       checksum_o
);

  state_e state_q, state_d;

  logic              accept;
  logic              session_start;
  logic              word_valid;
  logic [31:0]       word;

  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              err_q, err_d;
  logic              write_word;

  assign accept        = in_valid_i & in_ready_o;
  assign session_start = start_i & ((state_q == StIdle) | (state_q == StDone));

  im_word_pack u_pack (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (session_start),
    .accept_i     (accept),
    .flush_i      (in_last_i),
    .byte_i       (in_byte_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StLoad;
      StLoad:  if (accept && in_last_i) state_d = StFlush;
      StFlush: state_d = StDone;
      StDone:  if (start_i) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready_o = (state_q == StLoad);
    cpu_hold_o = (state_q != StDone);
    busy_o     = (state_q == StLoad) | (state_q == StFlush);
    done_o     = (state_q == StDone);
  end

  // The MSB of word_count marks a full memory; further completed words are dropped.
  assign write_word = word_valid & ~word_count_q[ADDR_W];

  always_comb begin
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    if (session_start) begin
      word_count_d = '0;
      err_d        = 1'b0;
    end else if (word_valid) begin
      if (write_word) begin
        im_we_d      = 1'b1;
        im_addr_d    = word_count_q[ADDR_W-1:0];
        im_wdata_d   = word;
        word_count_d = word_count_q + (ADDR_W + 1)'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
    end
  end

  assign im_we_o      = im_we_q;
  assign im_addr_o    = im_addr_q;
  assign im_wdata_o   = im_wdata_q;
  assign word_count_o = word_count_q;
  assign err_o        = err_q;

`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (session_start) begin
      checksum_d = '0;
    end else if (write_word) begin
      checksum_d = checksum_q ^ word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum_o = checksum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;
  logic [31:0]       checksum;

  always #5 clk = ~clk;

  im_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .in_byte_i    (in_byte),
    .in_valid_i   (in_valid),
    .in_last_i    (in_last),
    .in_ready_o   (in_ready),
    .im_we_o      (im_we),
    .im_addr_o    (im_addr),
    .im_wdata_o   (im_wdata),
    .cpu_hold_o   (cpu_hold),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .word_count_o (word_count),
    .checksum_o   (checksum)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim[$];

  int          exp_words;
  bit          exp_err;
  logic [31:0] exp_ck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every IM write must match the next expected write.
  wr_t mon_e;
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_im_we", 32'(im_addr), 32'hffff_ffff);
      end else begin
        mon_e = exp_q.pop_front();
        chk("im_addr", 32'(im_addr), 32'(mon_e.addr));
        chk("im_wdata", im_wdata, mon_e.data);
      end
    end
  end

  // Reference model: the image is cut into 4-byte big-endian words, the final one padded
  // with zeros; only the first DEPTH words fit in memory.
  task automatic model(input int n, input bit complete);
    int          nwords;
    logic [31:0] w;
    wr_t         e;
    nwords    = complete ? (n + 3) / 4 : n / 4;
    exp_words = 0;
    exp_err   = 1'b0;
    exp_ck    = 32'h0;
    for (int i = 0; i < nwords; i++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++) begin
        if (4 * i + j < n) w = w | (32'(stim[4 * i + j]) << (24 - 8 * j));
      end
      if (i < int'(DEPTH)) begin
        e.addr = ADDR_W'(i);
        e.data = w;
        exp_q.push_back(e);
        exp_ck = exp_ck ^ w;
        exp_words++;
      end else begin
        exp_err = 1'b1;
      end
    end
  endtask

  // Drives stim[0..n-1]; called on a negedge, returns on the negedge after the last accept.
  // gap_mode: 0 back-to-back, 1 idle cycle after each byte, 2 random idle cycles.
  task automatic feed(input int n, input bit mark_last, input int gap_mode, input bit rnd_start);
    int waited;
    for (int k = 0; k < n; k++) begin
      in_byte  = stim[k];
      in_last  = mark_last && (k == n - 1);
      in_valid = 1'b1;
      start    = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      waited   = 0;
      while (in_ready !== 1'b1) begin
        @(negedge clk);
        waited++;
        if (waited > 20) begin
          chk("byte_accept_timeout", 32'(k), 32'hffff_ffff);
          in_valid = 1'b0;
          start    = 1'b0;
          return;
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
      if (k != n - 1) begin
        if (gap_mode == 1) @(negedge clk);
        else if (gap_mode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  task automatic begin_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ready_after_start", 32'(in_ready), 32'h1);
    chk("count_cleared", 32'(word_count), 32'h0);
  endtask

  task automatic session(input int gap_mode, input bit rnd_start);
    int n;
    n = stim.size();
    model(n, 1'b1);
    begin_session();
    feed(n, 1'b1, gap_mode, rnd_start);
    chk("flush_done_low", 32'(done), 32'h0);
    chk("flush_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("done", 32'(done), 32'h1);
    chk("cpu_hold_released", 32'(cpu_hold), 32'h0);
    chk("done_ready_low", 32'(in_ready), 32'h0);
    chk("word_count", 32'(word_count), 32'(exp_words));
    chk("err", 32'(err), 32'(exp_err));
`ifdef IM_LOADER_CHECKSUM_EN
    chk("checksum", checksum, exp_ck);
`else
    chk("checksum_tied", checksum, 32'h0);
`endif
    chk("writes_pending", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_im_we", 32'(im_we), 32'h0);
    chk("rst_im_addr", 32'(im_addr), 32'h0);
    chk("rst_im_wdata", im_wdata, 32'h0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_word_count", 32'(word_count), 32'h0);
    chk("rst_checksum", checksum, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready_low", 32'(in_ready), 32'h0);

    // Two full words: 0x00003021, 0x8C010000
    stim = '{8'h00, 8'h00, 8'h30, 8'h21, 8'h8C, 8'h01, 8'h00, 8'h00};
    session(0, 1'b0);
`ifdef IM_LOADER_CHECKSUM_EN
    chk("checksum_directed", checksum, 32'h8C01_3021);
`endif

    // Partial final word from DONE: 0x12345678, 0x9A000000
    stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    session(0, 1'b0);

    // Same image as the first, with in_valid toggling
    stim = '{8'h00, 8'h00, 8'h30, 8'h21, 8'h8C, 8'h01, 8'h00, 8'h00};
    session(1, 1'b0);

    // Reset after 6 bytes: one word written, partial word discarded
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
    model(6, 1'b0);
    begin_session();
    feed(6, 1'b0, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready_low", 32'(in_ready), 32'h0);
    chk("abort_cpu_hold", 32'(cpu_hold), 32'h1);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_word_count", 32'(word_count), 32'h0);
    repeat (6) @(negedge clk);
    chk("abort_writes_pending", 32'(exp_q.size()), 32'h0);
    stim.delete();
    for (int i = 0; i < 9; i++) stim.push_back(8'($urandom));
    session(0, 1'b0);

    // Randomised images, gaps, and stray start pulses during loading
    for (int s = 0; s < 12; s++) begin
      stim.delete();
      repeat ($urandom_range(1, 40)) stim.push_back(8'($urandom));
      session(int'($urandom_range(0, 2)), 1'b1);
    end

    // Overflow: 4100 bytes = 1025 words, only 1024 fit
    stim.delete();
    for (int i = 0; i < 4100; i++) stim.push_back(8'($urandom));
    session(0, 1'b0);

    // Memory reusable after an overflow session
    stim.delete();
    repeat (7) stim.push_back(8'($urandom));
    session(2, 1'b0);

    summary();
    $finish;
  end

endmodule
